// File: rtl/scan_display.sv
// Time-multiplexed common-anode seven-segment driver: scans NUM_DIGITS hex digits,
// snapshots inputs once per frame, inserts a dark dead window at each slot start.
module scan_display #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 1000,
  parameter int DEAD       = 16,
  parameter int BLINK_DIV  = 250
) (
  input  logic                    CP_1MHz,
  input  logic                    CR,
  input  logic [4*NUM_DIGITS-1:0] iData,
  input  logic [NUM_DIGITS-1:0]   iDP,
  input  logic [NUM_DIGITS-1:0]   iBlank,
  input  logic [NUM_DIGITS-1:0]   iBlink,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              C,
  output logic                    DP
);

  localparam int DIV_W = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRM_W = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;

  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        idx;
  logic [FRM_W-1:0]        frame_cnt;
  logic                    blink_phase;
  logic                    first_seen;
  logic [4*NUM_DIGITS-1:0] sh_data;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic [NUM_DIGITS-1:0]   sh_blink;

  logic [3:0]              cur_nib;
  logic                    en;
  logic                    frame_start;
  logic                    div_wrap;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              c_next;
  logic                    dp_next;

  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    cur_nib     = sh_data[{idx, 2'b00} +: 4];
    frame_start = (div_cnt == '0) && (idx == '0);
    div_wrap    = (div_cnt == DIV_W'(SCAN_DIV - 1));
    // Blank overrides blink: either condition alone keeps the digit dark.
    en          = (div_cnt >= DIV_W'(DEAD)) && !sh_blank[idx] &&
                  !(sh_blink[idx] && blink_phase);
    an_next      = '1;
    an_next[idx] = ~en;
    c_next       = en ? seg_of(cur_nib) : 7'h7F;
    dp_next      = ~(en & sh_dp[idx]);
  end

  always_ff @(posedge CP_1MHz) begin
    if (CR) begin
      div_cnt     <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      first_seen  <= 1'b0;
      sh_data     <= '0;
      sh_dp       <= '0;
      sh_blank    <= '0;
      sh_blink    <= '0;
      AN          <= '1;
      C           <= 7'h7F;
      DP          <= 1'b1;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap)
        idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;

      if (frame_start) begin
        sh_data    <= iData;
        sh_dp      <= iDP;
        sh_blank   <= iBlank;
        sh_blink   <= iBlink;
        first_seen <= 1'b1;
        // The snapshot right after reset starts frame 0 and does not count.
        if (first_seen) begin
          if (frame_cnt == FRM_W'(BLINK_DIV - 1)) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      end

      AN <= an_next;
      C  <= c_next;
      DP <= dp_next;
    end
  end

endmodule

// File: tb/tb_scan_display.sv
// Directed bench for scan_display with NUM_DIGITS=4, SCAN_DIV=8, DEAD=2, BLINK_DIV=2.
module tb_scan_display;

  logic        clk;
  logic        CR;
  logic [15:0] iData;
  logic [3:0]  iDP;
  logic [3:0]  iBlank;
  logic [3:0]  iBlink;
  logic [3:0]  AN;
  logic [6:0]  C;
  logic        DP;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  scan_display #(
    .NUM_DIGITS(4),
    .SCAN_DIV  (8),
    .DEAD      (2),
    .BLINK_DIV (2)
  ) dut (
    .CP_1MHz(clk),
    .CR     (CR),
    .iData  (iData),
    .iDP    (iDP),
    .iBlank (iBlank),
    .iBlink (iBlink),
    .AN     (AN),
    .C      (C),
    .DP     (DP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Walk slot k from in-slot edge j_first to j_last (1..8). Edges 1-2 are dead.
  task automatic do_slot(input int k, input logic [6:0] seg, input logic lit,
                         input logic dpx, input int j_first, input int j_last);
    logic       on;
    logic [3:0] an_exp;
    for (int j = j_first; j <= j_last; j++) begin
      @(negedge clk);
      edge_n++;
      on     = lit && (j >= 3);
      an_exp = 4'hF;
      if (on) an_exp[k] = 1'b0;
      check($sformatf("AN_s%0d_e%0d", k, edge_n), {12'h0, AN}, {12'h0, an_exp});
      check($sformatf("C_s%0d_e%0d",  k, edge_n), {9'h0, C},
            {9'h0, (on ? seg : 7'h7F)});
      check($sformatf("DP_s%0d_e%0d", k, edge_n), {15'h0, DP}, {15'h0, ~(on & dpx)});
    end
  endtask

  initial begin
    CR     = 1'b1;
    iData  = 16'h3210;
    iDP    = 4'b0000;
    iBlank = 4'b0000;
    iBlink = 4'b0010;

    // Reset held for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("rst_AN_%0d", i), {12'h0, AN}, 16'h000F);
      check($sformatf("rst_C_%0d",  i), {9'h0, C},   16'h007F);
      check($sformatf("rst_DP_%0d", i), {15'h0, DP}, 16'h0001);
    end
    CR     = 1'b0;
    edge_n = 0;

    // Frame 0: 3210; data changes to FEDC while slot 1 is lit.
    do_slot(0, 7'h40, 1'b1, 1'b0, 1, 2);
    do_slot(0, 7'h40, 1'b1, 1'b0, 3, 3);
    check("first_lit_edge", edge_n[15:0], 16'd3);
    do_slot(0, 7'h40, 1'b1, 1'b0, 4, 8);
    do_slot(1, 7'h79, 1'b1, 1'b0, 1, 4);
    iData = 16'hFEDC;
    do_slot(1, 7'h79, 1'b1, 1'b0, 5, 8);
    do_slot(2, 7'h24, 1'b1, 1'b0, 1, 8);
    do_slot(3, 7'h30, 1'b1, 1'b0, 1, 8);

    // Frame 1: FEDC shown; masks change mid-frame and wait for frame 2.
    do_slot(0, 7'h46, 1'b1, 1'b0, 1, 8);
    do_slot(1, 7'h21, 1'b1, 1'b0, 1, 8);
    do_slot(2, 7'h06, 1'b1, 1'b0, 1, 8);
    do_slot(3, 7'h0E, 1'b1, 1'b0, 1, 4);
    iBlank = 4'b0100;
    iDP    = 4'b0001;
    iBlink = 4'b0110;
    do_slot(3, 7'h0E, 1'b1, 1'b0, 5, 8);

    // Frames 2..5: digit 2 blanked, DP on digit 0, digit 1 dark in frames 2-3.
    for (int f = 2; f <= 5; f++) begin
      do_slot(0, 7'h46, 1'b1, 1'b1, 1, 8);
      do_slot(1, 7'h21, (f >= 4), 1'b0, 1, 8);
      do_slot(2, 7'h06, 1'b0, 1'b0, 1, 8);
      do_slot(3, 7'h0E, 1'b1, 1'b0, 1, 8);
    end

    // Frame 6: blink phase dark again; reset lands while digit 3 is lit.
    do_slot(0, 7'h46, 1'b1, 1'b1, 1, 8);
    do_slot(1, 7'h21, 1'b0, 1'b0, 1, 8);
    do_slot(2, 7'h06, 1'b0, 1'b0, 1, 8);
    do_slot(3, 7'h0E, 1'b1, 1'b0, 1, 5);
    CR = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("mid_rst_AN_%0d", i), {12'h0, AN}, 16'h000F);
      check($sformatf("mid_rst_C_%0d",  i), {9'h0, C},   16'h007F);
      check($sformatf("mid_rst_DP_%0d", i), {15'h0, DP}, 16'h0001);
    end
    CR     = 1'b0;
    edge_n = 0;

    // Restart at digit 0 with blink phase cleared: digit 1 lit in frames 0-1, dark in 2.
    for (int f = 0; f <= 2; f++) begin
      do_slot(0, 7'h46, 1'b1, 1'b1, 1, 8);
      do_slot(1, 7'h21, (f <= 1), 1'b0, 1, 8);
      do_slot(2, 7'h06, 1'b0, 1'b0, 1, 8);
      do_slot(3, 7'h0E, 1'b1, 1'b0, 1, 8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
